// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Memory-access pipeline stage. Registers the EX->MEM bus, holds
//            SRAM read data across stalls, extracts/extends sub-word loads and
//            drives the MEM->WB and MEM->ID buses.
// Options  : MEM_ADEL_CHECK_EN enables misaligned-load detection (adel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int STALL_W  = 6,
  parameter int EX_MEM_W = 146,
  parameter int MEM_WB_W = 136,
  parameter int MEM_ID_W = 104
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic [EX_MEM_W-1:0] ex_to_mem_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic [MEM_WB_W-1:0] mem_to_wb_bus,
  output logic [MEM_ID_W-1:0] mem_to_id_bus,
  output logic                adel
);

  localparam logic [3:0] c_LD_LW  = 4'b1111;
  localparam logic [3:0] c_LD_LB  = 4'b0001;
  localparam logic [3:0] c_LD_LBU = 4'b0010;
  localparam logic [3:0] c_LD_LH  = 4'b0011;
  localparam logic [3:0] c_LD_LHU = 4'b0100;

  logic [EX_MEM_W-1:0] r_bus;
  logic                r_fresh;
  logic [31:0]         r_rdata_hold;

  // r_fresh marks the first cycle after r_bus loaded, when the SRAM output
  // still belongs to this instruction; afterwards the captured copy is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus        <= '0;
      r_fresh      <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      if (r_fresh) begin
        r_rdata_hold <= data_sram_rdata;
      end
      if (stall[3] && !stall[4]) begin
        r_bus   <= '0;
        r_fresh <= 1'b1;
      end else if (!stall[3]) begin
        r_bus   <= ex_to_mem_bus;
        r_fresh <= 1'b1;
      end else begin
        r_fresh <= 1'b0;
      end
    end
  end

  logic [3:0]  w_readen;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [31:0] w_pc;
  logic        w_ram_en;
  logic [3:0]  w_ram_wen;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_ex_result;
  logic [1:0]  w_addr_lo;

  assign w_readen     = r_bus[145:142];
  assign w_hi_we      = r_bus[141];
  assign w_lo_we      = r_bus[140];
  assign w_hi         = r_bus[139:108];
  assign w_lo         = r_bus[107:76];
  assign w_pc         = r_bus[75:44];
  assign w_ram_en     = r_bus[43];
  assign w_ram_wen    = r_bus[42:39];
  assign w_sel_rf_res = r_bus[38];
  assign w_rf_we      = r_bus[37];
  assign w_rf_waddr   = r_bus[36:32];
  assign w_ex_result  = r_bus[31:0];
  assign w_addr_lo    = w_ex_result[1:0];

  logic [31:0] w_ld_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_value;
  logic [31:0] w_rf_wdata;

  assign w_ld_word = r_fresh ? data_sram_rdata : r_rdata_hold;

  always_comb begin
    w_byte = w_ld_word[7:0];
    case (w_addr_lo)
      2'b00:   w_byte = w_ld_word[7:0];
      2'b01:   w_byte = w_ld_word[15:8];
      2'b10:   w_byte = w_ld_word[23:16];
      default: w_byte = w_ld_word[31:24];
    endcase
  end

  assign w_half = w_addr_lo[1] ? w_ld_word[31:16] : w_ld_word[15:0];

  // Unlisted readen codes (including stores) fall back to a full word.
  always_comb begin
    w_ld_value = w_ld_word;
    case (w_readen)
      c_LD_LB:  w_ld_value = {{24{w_byte[7]}}, w_byte};
      c_LD_LBU: w_ld_value = {24'h000000, w_byte};
      c_LD_LH:  w_ld_value = {{16{w_half[15]}}, w_half};
      c_LD_LHU: w_ld_value = {16'h0000, w_half};
      default:  w_ld_value = w_ld_word;
    endcase
  end

  assign w_rf_wdata = w_sel_rf_res ? w_ld_value : w_ex_result;

  logic w_adel;

`ifdef MEM_ADEL_CHECK_EN
  always_comb begin
    w_adel = 1'b0;
    if (w_sel_rf_res) begin
      if (w_readen == c_LD_LW && w_addr_lo != 2'b00) begin
        w_adel = 1'b1;
      end else if ((w_readen == c_LD_LH || w_readen == c_LD_LHU) && w_addr_lo[0]) begin
        w_adel = 1'b1;
      end
    end
  end
`else
  assign w_adel = 1'b0;
`endif

  logic w_rf_we_out;

  assign w_rf_we_out = w_rf_we & ~w_adel;
  assign adel        = w_adel;

  assign mem_to_wb_bus = {w_hi_we, w_lo_we, w_hi, w_lo, w_pc,
                          w_rf_we_out, w_rf_waddr, w_rf_wdata};

  assign mem_to_id_bus = {w_rf_we_out, w_rf_waddr, w_rf_wdata,
                          w_hi_we, w_lo_we, w_hi, w_lo};

  // Fields that this stage carries but does not consume.
  logic w_unused;
  assign w_unused = ^{stall[STALL_W-1:5], stall[2:0], w_ram_en, w_ram_wen};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [145:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_id_bus;
  logic         adel;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus),
    .adel            (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [145:0] mk_ex(input logic [3:0] readen, input logic hi_we,
                                          input logic lo_we, input logic [31:0] hi,
                                          input logic [31:0] lo, input logic [31:0] pc,
                                          input logic sel, input logic rf_we,
                                          input logic [4:0] waddr, input logic [31:0] res);
    return {readen, hi_we, lo_we, hi, lo, pc, 1'b1, 4'b0000, sel, rf_we, waddr, res};
  endfunction

  function automatic logic [135:0] mk_wb(input logic hi_we, input logic lo_we,
                                          input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [31:0] pc, input logic rf_we,
                                          input logic [4:0] waddr, input logic [31:0] wdata);
    return {hi_we, lo_we, hi, lo, pc, rf_we, waddr, wdata};
  endfunction

  function automatic logic [103:0] mk_id(input logic hi_we, input logic lo_we,
                                          input logic [31:0] hi, input logic [31:0] lo,
                                          input logic rf_we, input logic [4:0] waddr,
                                          input logic [31:0] wdata);
    return {rf_we, waddr, wdata, hi_we, lo_we, hi, lo};
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 6'b000000;
    data_sram_rdata = 32'hFFFF_FFFF;
    ex_to_mem_bus = mk_ex(4'b1111, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222,
                          32'h3333_3333, 1'b1, 1'b1, 5'd9, 32'h4444_4444);
    tick();
    tick();
    n_total++;
    if (mem_to_wb_bus !== 136'd0) $display("FAIL reset_wb got %h want 0", mem_to_wb_bus);
    else n_pass++;
    n_total++;
    if (mem_to_id_bus !== 104'd0) $display("FAIL reset_id got %h want 0", mem_to_id_bus);
    else n_pass++;
    n_total++;
    if (adel !== 1'b0) $display("FAIL reset_adel got %b want 0", adel);
    else n_pass++;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    ex_to_mem_bus = mk_ex(4'b0000, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0100,
                          1'b0, 1'b1, 5'd5, 32'h1234_5678);
    data_sram_rdata = 32'hAAAA_5555;
    tick();
    n_total++;
    if (mem_to_wb_bus !== mk_wb(1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0100, 1'b1, 5'd5, 32'h1234_5678))
      $display("FAIL alu_wb got %h want rf_we=1 waddr=5 wdata=12345678", mem_to_wb_bus);
    else n_pass++;
    n_total++;
    if (mem_to_id_bus !== mk_id(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234_5678))
      $display("FAIL alu_id got %h want rf_we=1 waddr=5 wdata=12345678", mem_to_id_bus);
    else n_pass++;
  endtask

  typedef struct {
    logic [3:0]  readen;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] want;
  } load_vec_t;

  task automatic test_loads();
    load_vec_t vecs[9];
    vecs[0] = '{4'b0001, 1'b1, 32'h0000_1003, 32'hFFFF_FF80};
    vecs[1] = '{4'b0010, 1'b1, 32'h0000_1002, 32'h0000_00FF};
    vecs[2] = '{4'b0011, 1'b1, 32'h0000_1002, 32'hFFFF_80FF};
    vecs[3] = '{4'b0100, 1'b1, 32'h0000_1000, 32'h0000_7F01};
    vecs[4] = '{4'b0001, 1'b1, 32'h0000_1001, 32'h0000_007F};
    vecs[5] = '{4'b0011, 1'b1, 32'h0000_1000, 32'h0000_7F01};
    vecs[6] = '{4'b1111, 1'b1, 32'h0000_1000, 32'h80FF_7F01};
    vecs[7] = '{4'b0101, 1'b1, 32'h0000_1000, 32'h80FF_7F01};
    vecs[8] = '{4'b0001, 1'b0, 32'h0000_1003, 32'h0000_1003};
    stall = 6'b000000;
    for (int i = 0; i < 9; i++) begin
      ex_to_mem_bus = mk_ex(vecs[i].readen, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0200,
                            vecs[i].sel, 1'b1, 5'd7, vecs[i].addr);
      data_sram_rdata = 32'h1357_9BDF;
      tick();
      data_sram_rdata = 32'h80FF_7F01;
      #1;
      n_total++;
      if (mem_to_wb_bus !== mk_wb(1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0200, 1'b1, 5'd7, vecs[i].want)
          || adel !== 1'b0)
        $display("FAIL load_%0d got wb=%h adel=%b want wdata=%h adel=0",
                 i, mem_to_wb_bus, adel, vecs[i].want);
      else n_pass++;
    end
  endtask

  task automatic test_stall_hold();
    stall = 6'b000000;
    ex_to_mem_bus = mk_ex(4'b1111, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0300,
                          1'b1, 1'b1, 5'd10, 32'h0000_2000);
    tick();
    data_sram_rdata = 32'hCAFE_BABE;
    stall = 6'b011000;
    ex_to_mem_bus = mk_ex(4'b0000, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0400,
                          1'b0, 1'b1, 5'd11, 32'h5555_5555);
    #1;
    n_total++;
    if (mem_to_wb_bus[31:0] !== 32'hCAFE_BABE)
      $display("FAIL hold_first got %h want cafebabe", mem_to_wb_bus[31:0]);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if (mem_to_wb_bus !== mk_wb(1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0300, 1'b1, 5'd10, 32'hCAFE_BABE)
          || mem_to_id_bus !== mk_id(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd10, 32'hCAFE_BABE))
        $display("FAIL hold_cycle%0d got wb=%h want wdata=cafebabe pc=300", c, mem_to_wb_bus);
      else n_pass++;
    end
    // Reset while still stalled must clear everything on that same edge.
    rst = 1'b1;
    tick();
    n_total++;
    if (mem_to_wb_bus !== 136'd0 || mem_to_id_bus !== 104'd0)
      $display("FAIL reset_mid_stall got wb=%h id=%h want 0", mem_to_wb_bus, mem_to_id_bus);
    else n_pass++;
    rst = 1'b0;
    stall = 6'b000000;
  endtask

  task automatic test_bubble();
    stall = 6'b000000;
    ex_to_mem_bus = mk_ex(4'b0000, 1'b1, 1'b1, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_0500,
                          1'b0, 1'b1, 5'd12, 32'h0BAD_F00D);
    tick();
    n_total++;
    if (mem_to_wb_bus !== mk_wb(1'b1, 1'b1, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_0500,
                                1'b1, 5'd12, 32'h0BAD_F00D))
      $display("FAIL pre_bubble got %h want loaded instruction", mem_to_wb_bus);
    else n_pass++;
    stall = 6'b001000;
    tick();
    n_total++;
    if (mem_to_wb_bus !== 136'd0 || mem_to_id_bus !== 104'd0)
      $display("FAIL bubble got wb=%h id=%h want 0", mem_to_wb_bus, mem_to_id_bus);
    else n_pass++;
    stall = 6'b000000;
  endtask

  task automatic test_hilo();
    stall = 6'b000000;
    ex_to_mem_bus = mk_ex(4'b0000, 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0600,
                          1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    n_total++;
    if (mem_to_wb_bus !== mk_wb(1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0600,
                                1'b0, 5'd0, 32'd0))
      $display("FAIL hilo_wb got %h want hi=1 lo=fffffffe", mem_to_wb_bus);
    else n_pass++;
    n_total++;
    if (mem_to_id_bus !== mk_id(1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 5'd0, 32'd0))
      $display("FAIL hilo_id got %h want hi=1 lo=fffffffe", mem_to_id_bus);
    else n_pass++;
  endtask

  task automatic test_adel();
    logic exp_adel;
    logic exp_we;
`ifdef MEM_ADEL_CHECK_EN
    exp_adel = 1'b1;
`else
    exp_adel = 1'b0;
`endif
    exp_we = ~exp_adel;
    stall = 6'b000000;
    ex_to_mem_bus = mk_ex(4'b1111, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0700,
                          1'b1, 1'b1, 5'd13, 32'h0000_1002);
    tick();
    data_sram_rdata = 32'h0102_0304;
    #1;
    n_total++;
    if (adel !== exp_adel || mem_to_wb_bus[37] !== exp_we || mem_to_id_bus[103] !== exp_we)
      $display("FAIL adel_lw got adel=%b we=%b/%b want adel=%b we=%b",
               adel, mem_to_wb_bus[37], mem_to_id_bus[103], exp_adel, exp_we);
    else n_pass++;
    ex_to_mem_bus = mk_ex(4'b0100, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0704,
                          1'b1, 1'b1, 5'd14, 32'h0000_1001);
    tick();
    #1;
    n_total++;
    if (adel !== exp_adel || mem_to_wb_bus[37] !== exp_we)
      $display("FAIL adel_lhu got adel=%b we=%b want adel=%b we=%b",
               adel, mem_to_wb_bus[37], exp_adel, exp_we);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b000000;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    #2;
    test_reset();
    test_alu_pass();
    test_loads();
    test_stall_hold();
    test_bubble();
    test_hilo();
    test_adel();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
